horizontal_rocket_launcher: RTL

//  Initiator side of the horizontal-rocket interface. Decides when and from which of 4 spawn slots a

---
 rtl/rocket_pkg.sv | 33 +++
 rtl/lfsr16.sv | 28 ++
 rtl/horizontal_rocket_launcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rocket_pkg.sv
// Shared definitions for the horizontal-rocket interface: launcher states,
// per-level cooldown table and the spawn-slot numbering used by both sides.
package rocket_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    WARN,
    FIRE,
    WAIT_ACK,
    WAIT_DONE
  } launcher_state_t;

  localparam int NUM_SPAWN_SLOTS = 4;
  localparam int SLOT_IDX_W      = $clog2(NUM_SPAWN_SLOTS);
  localparam int RAND_LOC_W      = 3;

  // Index 0 is the easiest level (longest cooldown).
  localparam logic [0:3][9:0] COOLDOWN_BASE = {10'd240, 10'd180, 10'd120, 10'd60};

  // Slots 0,1 spawn at the left edge, 2,3 at the right edge; bit2 is always 0.
  typedef enum logic [RAND_LOC_W-1:0] {
    SLOT_LEFT_0  = 3'd0,
    SLOT_LEFT_1  = 3'd1,
    SLOT_RIGHT_0 = 3'd2,
    SLOT_RIGHT_1 = 3'd3
  } spawn_slot_t;

  function automatic logic [RAND_LOC_W-1:0] slot_from_rand(input logic [SLOT_IDX_W-1:0] r);
    return {{(RAND_LOC_W-SLOT_IDX_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); an all-zero seed
// would lock up, so it is replaced by 1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] out
);

  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS      = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SAFE_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/horizontal_rocket_launcher.sv
// Decides when and from which spawn slot a horizontal rocket is fired, with a
// random per-level cooldown, a blinking pre-launch warning and an ack timeout.
module horizontal_rocket_launcher
  import rocket_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          WARN_FRAMES = 32,
  parameter int          BLINK_HALF  = 4,
  parameter int          JITTER_BITS = 6,
  parameter int          ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       isGameMode,
  input  logic [1:0] levelIndex,
  input  logic       isActiveHorizontal,
  output logic       shootPulse,
  output logic [2:0] randLoc,
  output logic       warningActive
);

  localparam int                 CNT_W     = 10;
  localparam int                 BLINK_BIT = $clog2(BLINK_HALF);
  localparam logic [CNT_W-1:0]   WARN_LOAD = CNT_W'(WARN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

  launcher_state_t  state_q, state_d;
  logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic [2:0]       randLoc_q, randLoc_d;
  logic             shootPulse_q, shootPulse_d;
  logic             warn_q, warn_d;
  logic [15:0]      lfsr;
  logic             frameDone;
  logic             unused_lfsr_hi;

  function automatic logic [CNT_W-1:0] cooldown_load(input logic [1:0] lvl,
                                                     input logic [JITTER_BITS-1:0] jitter);
    return COOLDOWN_BASE[lvl] + CNT_W'(jitter);
  endfunction

  // Warning is lit during even BLINK_HALF-frame windows since WARN entry.
  function automatic logic blink_off(input logic [CNT_W-1:0] cnt);
    return |(((WARN_LOAD - cnt) >> BLINK_BIT) & CNT_W'(1));
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .out    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:JITTER_BITS];
  assign frameDone      = startOfFrame && (frameCnt_q == '0);

  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    randLoc_d  = randLoc_q;
    if (startOfFrame && (frameCnt_q != '0)) frameCnt_d = frameCnt_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (isGameMode) begin
          state_d    = COOLDOWN;
          frameCnt_d = cooldown_load(levelIndex, lfsr[JITTER_BITS-1:0]);
        end
      end
      COOLDOWN: begin
        // A rocket still in flight keeps the counter parked at zero.
        if (frameDone && !isActiveHorizontal) begin
          state_d    = WARN;
          randLoc_d  = slot_from_rand(lfsr[SLOT_IDX_W-1:0]);
          frameCnt_d = WARN_LOAD;
        end
      end
      WARN: begin
        if (frameDone) state_d = FIRE;
      end
      FIRE: begin
        state_d    = WAIT_ACK;
        frameCnt_d = ACK_LOAD;
      end
      WAIT_ACK: begin
        if (isActiveHorizontal) begin
          state_d = WAIT_DONE;
        end else if (frameDone) begin
          state_d    = COOLDOWN;
          frameCnt_d = cooldown_load(levelIndex, lfsr[JITTER_BITS-1:0]);
        end
      end
      WAIT_DONE: begin
        if (!isActiveHorizontal) begin
          state_d    = COOLDOWN;
          frameCnt_d = cooldown_load(levelIndex, lfsr[JITTER_BITS-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!isGameMode) state_d = IDLE;

    shootPulse_d = (state_d == FIRE);
    warn_d       = (state_d == WARN) && !blink_off(frameCnt_d);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      frameCnt_q   <= '0;
      randLoc_q    <= '0;
      shootPulse_q <= 1'b0;
      warn_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frameCnt_q   <= frameCnt_d;
      randLoc_q    <= randLoc_d;
      shootPulse_q <= shootPulse_d;
      warn_q       <= warn_d;
    end
  end

  assign shootPulse    = shootPulse_q;
  assign randLoc       = randLoc_q;
  assign warningActive = warn_q;

endmodule
